uart_game_link: RTL and testbench

Parametrised link-layer controller between game logic and the UART FIFO pair (FWFT RX FIFO, TX FIFO) in the two-player build.
- Performs a start handshake with the peer board, with retries.
- Then exchanges framed multi-byte scores full-duplex: header byte followed by DATA_BYTES payload bytes, MSB first.
- Adds what the single-byte exchange lacks: FIFO flow control, payload width, retry/timeout, frame resynchronisation and a one-deep TX request buffer.

---
 rtl/uart_game_link_if.sv | 34 +++
 rtl/uart_game_link.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_game_link.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_game_link_if.sv
// Bundle of the UART FIFO pair signals seen by the game link controller.
//   rx_data  : RX FIFO head byte (first-word-fall-through), valid while rx_empty=0
//   rx_empty : RX FIFO empty flag
//   tx_full  : TX FIFO full flag
//   rd_uart  : RX FIFO pop strobe, one per consumed byte
//   wr_uart  : TX FIFO push strobe, one per sent byte
//   tx_data  : byte written into the TX FIFO when wr_uart=1
// The master modport is the link controller; the slave modport is the FIFO side.
interface uart_game_link_if;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       tx_full;
    logic       rd_uart;
    logic       wr_uart;
    logic [7:0] tx_data;

    modport master (
        input  rx_data,
        input  rx_empty,
        input  tx_full,
        output rd_uart,
        output wr_uart,
        output tx_data
    );

    modport slave (
        output rx_data,
        output rx_empty,
        output tx_full,
        input  rd_uart,
        input  wr_uart,
        input  tx_data
    );
endinterface

// File: rtl/uart_game_link.sv
// Link-layer controller between the game logic and the UART FIFO pair.
// Runs a START_BYTE handshake with retries, then exchanges framed scores
// (SCORE_HDR followed by DATA_BYTES payload bytes, MSB first) in both
// directions at once.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   fifo         : UART FIFO pair (uart_game_link_if.master)
//   link_start   : pulse, begin the handshake (IDLE only)
//   my_score     : local score, sampled when score_send pulses
//   score_send   : pulse, transmit my_score (LINKED only)
//   peer_score   : last complete score received from the peer
//   peer_valid   : one-cycle pulse when peer_score updates
//   link_up      : high while LINKED
//   link_timeout : sticky, handshake retries exhausted
//   busy         : a TX frame is in flight or waiting in the pending buffer
module uart_game_link #(
    parameter int         DATA_BYTES     = 2,
    parameter logic [7:0] START_BYTE     = 8'hFF,
    parameter logic [7:0] SCORE_HDR      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         MAX_RETRY      = 8,
    parameter int         TO_W           = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_game_link_if.master        fifo,
    input  logic                    link_start,
    input  logic [8*DATA_BYTES-1:0] my_score,
    input  logic                    score_send,
    output logic [8*DATA_BYTES-1:0] peer_score,
    output logic                    peer_valid,
    output logic                    link_up,
    output logic                    link_timeout,
    output logic                    busy
);
    localparam int SW      = 8 * DATA_BYTES;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {IDLE, SYNC, LINKED} link_state_t;
    typedef enum logic {HUNT, PAYLOAD} rx_state_t;

    link_state_t        link_state_q, link_state_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [TO_W-1:0]    sync_timer_q, sync_timer_d;
    logic               link_timeout_q, link_timeout_d;

    // Single-byte TX slot feeding the FIFO; tx_data_q holds steady while tx_full.
    logic               tx_pending_q, tx_pending_d;
    logic [7:0]         tx_data_q, tx_data_d;

    logic               frame_active_q, frame_active_d;
    logic [IDX_W-1:0]   frame_idx_q, frame_idx_d;
    logic [SW-1:0]      frame_word_q, frame_word_d;
    logic               pend_valid_q, pend_valid_d;
    logic [SW-1:0]      pend_word_q, pend_word_d;

    rx_state_t          rx_state_q, rx_state_d;
    logic [IDX_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [SW-1:0]      rx_shift_q, rx_shift_d;
    logic [TO_W-1:0]    rx_timer_q, rx_timer_d;
    logic [SW-1:0]      peer_score_q, peer_score_d;
    logic               peer_valid_q, peer_valid_d;

    logic               rd_uart;
    logic               wr_uart;
    logic               slot_free;

    assign rd_uart   = (link_state_q != IDLE) && !fifo.rx_empty;
    assign wr_uart   = tx_pending_q && !fifo.tx_full;
    // The slot can take a new byte when empty or when it empties on this edge.
    assign slot_free = !tx_pending_q || wr_uart;

    assign fifo.rd_uart = rd_uart;
    assign fifo.wr_uart = wr_uart;
    assign fifo.tx_data = tx_data_q;

    assign peer_score   = peer_score_q;
    assign peer_valid   = peer_valid_q;
    assign link_up      = (link_state_q == LINKED);
    assign link_timeout = link_timeout_q;
    assign busy         = frame_active_q || pend_valid_q;

    always_comb begin
        link_state_d   = link_state_q;
        retry_cnt_d    = retry_cnt_q;
        sync_timer_d   = sync_timer_q;
        link_timeout_d = link_timeout_q;
        tx_pending_d   = tx_pending_q;
        tx_data_d      = tx_data_q;
        frame_active_d = frame_active_q;
        frame_idx_d    = frame_idx_q;
        frame_word_d   = frame_word_q;
        pend_valid_d   = pend_valid_q;
        pend_word_d    = pend_word_q;
        rx_state_d     = rx_state_q;
        rx_cnt_d       = rx_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_timer_d     = rx_timer_q;
        peer_score_d   = peer_score_q;
        peer_valid_d   = 1'b0;

        if (wr_uart) begin
            tx_pending_d = 1'b0;
        end

        unique case (link_state_q)
            IDLE: begin
                if (link_start) begin
                    link_state_d   = SYNC;
                    retry_cnt_d    = '0;
                    sync_timer_d   = '0;
                    link_timeout_d = 1'b0;
                    tx_pending_d   = 1'b1;
                    tx_data_d      = START_BYTE;
                end
            end

            SYNC: begin
                // The silence timer counts from the push cycle itself (push -> 1),
                // so a retry push lands exactly TIMEOUT_CYCLES after the previous one.
                if (wr_uart) begin
                    retry_cnt_d  = retry_cnt_q + RETRY_W'(1);
                    sync_timer_d = TO_W'(1);
                end else if (!tx_pending_q) begin
                    if (sync_timer_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        sync_timer_d = '0;
                        if (retry_cnt_q == RETRY_W'(MAX_RETRY)) begin
                            link_timeout_d = 1'b1;
                            link_state_d   = IDLE;
                        end else begin
                            tx_pending_d = 1'b1;
                            tx_data_d    = START_BYTE;
                        end
                    end else begin
                        sync_timer_d = sync_timer_q + TO_W'(1);
                    end
                end
                // A peer START wins over a simultaneous retry exhaustion; the
                // extra START lets a late-starting peer link as well.
                if (rd_uart && (fifo.rx_data == START_BYTE)) begin
                    link_state_d   = LINKED;
                    link_timeout_d = 1'b0;
                    tx_pending_d   = 1'b1;
                    tx_data_d      = START_BYTE;
                end
            end

            LINKED: begin
                if (score_send) begin
                    if (frame_active_q) begin
                        pend_valid_d = 1'b1;
                        pend_word_d  = my_score;
                    end else begin
                        frame_active_d = 1'b1;
                        frame_idx_d    = '0;
                        frame_word_d   = my_score;
                    end
                end

                // frame_idx counts bytes loaded into the slot; once all are loaded
                // the frame stays active until its last byte is actually pushed.
                if (frame_active_q) begin
                    if (frame_idx_q == IDX_W'(DATA_BYTES + 1)) begin
                        if (wr_uart) begin
                            frame_active_d = pend_valid_d;
                            frame_idx_d    = '0;
                            frame_word_d   = pend_word_d;
                            pend_valid_d   = 1'b0;
                        end
                    end else if (slot_free) begin
                        tx_pending_d = 1'b1;
                        frame_idx_d  = frame_idx_q + IDX_W'(1);
                        if (frame_idx_q == '0) begin
                            tx_data_d = SCORE_HDR;
                        end else begin
                            tx_data_d    = frame_word_q[SW-1 -: 8];
                            frame_word_d = frame_word_q << 8;
                        end
                    end
                end

                if (rd_uart) begin
                    rx_timer_d = TO_W'(1);
                    unique case (rx_state_q)
                        HUNT: begin
                            if (fifo.rx_data == SCORE_HDR) begin
                                rx_state_d = PAYLOAD;
                                rx_cnt_d   = '0;
                            end
                        end
                        PAYLOAD: begin
                            rx_shift_d = (rx_shift_q << 8) | SW'(fifo.rx_data);
                            if (rx_cnt_q == IDX_W'(DATA_BYTES - 1)) begin
                                peer_score_d = rx_shift_d;
                                peer_valid_d = 1'b1;
                                rx_state_d   = HUNT;
                            end else begin
                                rx_cnt_d = rx_cnt_q + IDX_W'(1);
                            end
                        end
                        default: rx_state_d = HUNT;
                    endcase
                end else if (rx_state_q == PAYLOAD) begin
                    if (rx_timer_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        rx_state_d = HUNT;
                    end else begin
                        rx_timer_d = rx_timer_q + TO_W'(1);
                    end
                end
            end

            default: link_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_state_q   <= IDLE;
            retry_cnt_q    <= '0;
            sync_timer_q   <= '0;
            link_timeout_q <= 1'b0;
            tx_pending_q   <= 1'b0;
            tx_data_q      <= '0;
            frame_active_q <= 1'b0;
            frame_idx_q    <= '0;
            frame_word_q   <= '0;
            pend_valid_q   <= 1'b0;
            pend_word_q    <= '0;
            rx_state_q     <= HUNT;
            rx_cnt_q       <= '0;
            rx_shift_q     <= '0;
            rx_timer_q     <= '0;
            peer_score_q   <= '0;
            peer_valid_q   <= 1'b0;
        end else begin
            link_state_q   <= link_state_d;
            retry_cnt_q    <= retry_cnt_d;
            sync_timer_q   <= sync_timer_d;
            link_timeout_q <= link_timeout_d;
            tx_pending_q   <= tx_pending_d;
            tx_data_q      <= tx_data_d;
            frame_active_q <= frame_active_d;
            frame_idx_q    <= frame_idx_d;
            frame_word_q   <= frame_word_d;
            pend_valid_q   <= pend_valid_d;
            pend_word_q    <= pend_word_d;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_timer_q     <= rx_timer_d;
            peer_score_q   <= peer_score_d;
            peer_valid_q   <= peer_valid_d;
        end
    end
endmodule

// File: tb/tb_uart_game_link.sv
// Directed bench for uart_game_link (DATA_BYTES=2, TIMEOUT_CYCLES=100, MAX_RETRY=3).
// A peer model feeds an RX byte queue into the FWFT interface, logs every TX
// push with its cycle number, and optionally toggles tx_full for back-pressure.
module tb_uart_game_link;
    logic        clk = 1'b0;
    logic        rst;
    logic        link_start;
    logic        score_send;
    logic [15:0] my_score;
    logic [15:0] peer_score;
    logic        peer_valid;
    logic        link_up;
    logic        link_timeout;
    logic        busy;

    uart_game_link_if fifo_if();

    uart_game_link #(
        .DATA_BYTES(2),
        .START_BYTE(8'hFF),
        .SCORE_HDR(8'hA5),
        .TIMEOUT_CYCLES(100),
        .MAX_RETRY(3),
        .TO_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo(fifo_if),
        .link_start(link_start),
        .my_score(my_score),
        .score_send(score_send),
        .peer_score(peer_score),
        .peer_valid(peer_valid),
        .link_up(link_up),
        .link_timeout(link_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int         check_count = 0;
    int         fail_count = 0;
    int         cycle_cnt = 0;
    int         peer_valid_cnt = 0;
    int         full_violations = 0;
    logic       tx_full_mode = 1'b0;
    logic [7:0] peer_q[$];
    logic [7:0] tx_log[$];
    int         tx_times[$];

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Peer/FIFO model: drive the FIFO flags mid-cycle, then record what the
    // DUT pops and pushes on the coming edge.
    always @(negedge clk) begin
        logic [7:0] dropped;
        fifo_if.rx_empty = (peer_q.size() == 0);
        fifo_if.rx_data  = (peer_q.size() == 0) ? 8'h00 : peer_q[0];
        fifo_if.tx_full  = tx_full_mode & cycle_cnt[0];
        #1;
        if (fifo_if.rd_uart) dropped = peer_q.pop_front();
        if (fifo_if.wr_uart) begin
            if (fifo_if.tx_full) full_violations++;
            tx_log.push_back(fifo_if.tx_data);
            tx_times.push_back(cycle_cnt);
        end
        if (peer_valid) peer_valid_cnt++;
    end

    function automatic int log_at(input int i);
        return (i < tx_log.size()) ? int'(tx_log[i]) : -1;
    endfunction

    function automatic int time_at(input int i);
        return (i < tx_times.size()) ? tx_times[i] : -100000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic send, input logic [15:0] score);
        @(negedge clk);
        link_start = start;
        score_send = send;
        my_score   = score;
        @(negedge clk);
        link_start = 1'b0;
        score_send = 1'b0;
    endtask

    task automatic clearLog();
        tx_log.delete();
        tx_times.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        logic [7:0] exp_frames [6];
        exp_frames = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'h00, 8'h03};

        rst = 1'b1;
        link_start = 1'b0;
        score_send = 1'b0;
        my_score = 16'h0000;
        fifo_if.rx_empty = 1'b1;
        fifo_if.rx_data = 8'h00;
        fifo_if.tx_full = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rst_link_up", 32'(link_up), 32'd0);
        checkOutput("rst_link_timeout", 32'(link_timeout), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_peer_valid", 32'(peer_valid), 32'd0);
        checkOutput("rst_peer_score", 32'(peer_score), 32'd0);
        checkOutput("rst_wr_uart", 32'(fifo_if.wr_uart), 32'd0);
        checkOutput("rst_rd_uart", 32'(fifo_if.rd_uart), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Retry exhaustion: silent peer, three START pushes 100 cycles apart
        clearLog();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        seen = -1;
        for (int i = 0; i < 400 && seen < 0; i++) begin
            @(negedge clk);
            if (link_timeout) seen = cycle_cnt;
        end
        checkOutput("retry_timeout_set", 32'(seen >= 0), 32'd1);
        checkOutput("retry_push_count", 32'(tx_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) checkOutput($sformatf("retry_byte%0d", i), 32'(log_at(i)), 32'h0000_00FF);
        checkOutput("retry_spacing_1", 32'(time_at(1) - time_at(0)), 32'd100);
        checkOutput("retry_spacing_2", 32'(time_at(2) - time_at(1)), 32'd100);
        checkOutput("retry_timeout_delay", 32'(seen - time_at(2)), 32'd100);
        repeat (150) @(negedge clk);
        checkOutput("retry_no_extra_push", 32'(tx_log.size()), 32'd3);
        checkOutput("retry_link_up", 32'(link_up), 32'd0);
        checkOutput("retry_idle_no_pop", 32'(fifo_if.rd_uart), 32'd0);

        // Handshake: peer answers after 50 cycles, junk byte first
        clearLog();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("hs_timeout_cleared", 32'(link_timeout), 32'd0);
        repeat (50) @(negedge clk);
        checkOutput("hs_not_linked_early", 32'(link_up), 32'd0);
        peer_q.push_back(8'h3C);
        peer_q.push_back(8'hFF);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (link_up) seen = 1;
        end
        checkOutput("hs_link_up", 32'(link_up), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("hs_push_count", 32'(tx_log.size()), 32'd2);
        checkOutput("hs_byte0", 32'(log_at(0)), 32'h0000_00FF);
        checkOutput("hs_byte1", 32'(log_at(1)), 32'h0000_00FF);
        checkOutput("hs_rx_drained", 32'(peer_q.size()), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        repeat (5) @(negedge clk);
        checkOutput("hs_start_ignored", 32'(link_up), 32'd1);
        checkOutput("hs_no_new_push", 32'(tx_log.size()), 32'd2);

        // TX frame under toggling back-pressure
        clearLog();
        tx_full_mode = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h1234);
        checkOutput("tx_busy_set", 32'(busy), 32'd1);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        checkOutput("tx_busy_clears", 32'(busy), 32'd0);
        checkOutput("tx_push_count", 32'(tx_log.size()), 32'd3);
        checkOutput("tx_byte0", 32'(log_at(0)), 32'h0000_00A5);
        checkOutput("tx_byte1", 32'(log_at(1)), 32'h0000_0012);
        checkOutput("tx_byte2", 32'(log_at(2)), 32'h0000_0034);

        // Pending buffer: 0002 is overwritten by 0003
        clearLog();
        applyStimulus(1'b0, 1'b1, 16'h0001);
        applyStimulus(1'b0, 1'b1, 16'h0002);
        applyStimulus(1'b0, 1'b1, 16'h0003);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("pend_push_count", 32'(tx_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("pend_byte%0d", i), 32'(log_at(i)), 32'(exp_frames[i]));
        checkOutput("tx_no_push_when_full", 32'(full_violations), 32'd0);
        tx_full_mode = 1'b0;

        // RX resync: partial frame dropped after silence, then a full frame
        peer_valid_cnt = 0;
        peer_q.push_back(8'h07);
        peer_q.push_back(8'hA5);
        peer_q.push_back(8'h12);
        repeat (150) @(negedge clk);
        checkOutput("rx_partial_no_valid", 32'(peer_valid_cnt), 32'd0);
        checkOutput("rx_partial_score", 32'(peer_score), 32'd0);
        peer_q.push_back(8'hA5);
        peer_q.push_back(8'hAB);
        peer_q.push_back(8'hCD);
        repeat (10) @(negedge clk);
        checkOutput("rx_valid_count", 32'(peer_valid_cnt), 32'd1);
        checkOutput("rx_score_abcd", 32'(peer_score), 32'h0000_ABCD);
        peer_q.push_back(8'hFF);
        peer_q.push_back(8'hA5);
        peer_q.push_back(8'hA5);
        peer_q.push_back(8'h01);
        repeat (10) @(negedge clk);
        checkOutput("rx_hdr_as_data_count", 32'(peer_valid_cnt), 32'd2);
        checkOutput("rx_hdr_as_data_score", 32'(peer_score), 32'h0000_A501);

        // Async reset between payload bytes of an outgoing frame
        clearLog();
        tx_full_mode = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'hBEEF);
        for (int i = 0; i < 30 && tx_log.size() < 2; i++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_wr_uart", 32'(fifo_if.wr_uart), 32'd0);
        checkOutput("arst_rd_uart", 32'(fifo_if.rd_uart), 32'd0);
        checkOutput("arst_tx_data", 32'(fifo_if.tx_data), 32'd0);
        checkOutput("arst_link_up", 32'(link_up), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_peer_score", 32'(peer_score), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tx_full_mode = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("arst_push_count", 32'(tx_log.size()), 32'd2);
        checkOutput("arst_byte0", 32'(log_at(0)), 32'h0000_00A5);
        checkOutput("arst_byte1", 32'(log_at(1)), 32'h0000_00BE);
        checkOutput("arst_stays_down", 32'(link_up), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end
endmodule
